// File: rtl/ppc_types.sv
// Shared load/store types, access-size encodings and the combinational
// helpers used for byte-lane steering and load-result formatting.
// Lane k is the big-endian byte k of a 32-bit word, i.e. data bits
// [31-8k -: 8]; enable vectors carry lane 0 in bit 3 and lane 3 in bit 0.
package ppc_types;

    localparam logic [1:0] LSU_BYTE = 2'd0;
    localparam logic [1:0] LSU_HALF = 2'd1;
    localparam logic [1:0] LSU_WORD = 2'd3;

    typedef struct packed {
        logic [1:0] word_size;
        logic       sign_extend;
        logic       byte_reverse;
    } lsu_control_t;

    typedef struct packed {
        logic [1:0] offset;
        logic [1:0] size;
        logic       sign_extend;
        logic       byte_reverse;
    } lsu_track_t;

    function automatic logic [31:0] lsu_bswap(input logic [31:0] w);
        return {w[7:0], w[15:8], w[23:16], w[31:24]};
    endfunction

    // Size 2 is not a legal encoding, so it is always reported as misaligned.
    function automatic logic lsu_misaligned(input logic [1:0] size, input logic [1:0] offset);
        logic mis;
        case (size)
            LSU_BYTE: mis = 1'b0;
            LSU_HALF: mis = (offset == 2'd3);
            LSU_WORD: mis = (offset != 2'd0);
            default:  mis = 1'b1;
        endcase
        return mis;
    endfunction

    function automatic logic [3:0] lsu_lanes(input logic [1:0] size, input logic [1:0] offset);
        logic [3:0] lanes;
        case (size)
            LSU_BYTE: lanes = 4'b1000 >> offset;
            LSU_HALF: lanes = 4'b1100 >> offset;
            LSU_WORD: lanes = 4'b1111;
            default:  lanes = 4'b0000;
        endcase
        return lanes;
    endfunction

    // Places the low-order bytes of src MSB-first starting at lane offset.
    function automatic logic [31:0] lsu_steer(input logic [31:0] src, input logic [1:0] size,
                                              input logic [1:0] offset, input logic brev);
        logic [31:0] placed;
        logic [15:0] half;
        logic [4:0]  shamt;
        shamt = {offset, 3'b000};
        half  = brev ? {src[7:0], src[15:8]} : src[15:0];
        case (size)
            LSU_BYTE: placed = {src[7:0], 24'h0} >> shamt;
            LSU_HALF: placed = {half, 16'h0} >> shamt;
            LSU_WORD: placed = brev ? lsu_bswap(src) : src;
            default:  placed = 32'h0;
        endcase
        return placed;
    endfunction

    // Left-aligns the addressed lanes, optionally reverses them, then
    // right-justifies and extends to a full register value.
    function automatic logic [31:0] lsu_format(input logic [31:0] word, input lsu_track_t t);
        logic [31:0] aligned;
        logic [7:0]  b;
        logic [15:0] h;
        logic [31:0] res;
        aligned = word << {t.offset, 3'b000};
        b = aligned[31:24];
        h = t.byte_reverse ? {aligned[23:16], aligned[31:24]} : aligned[31:16];
        case (t.size)
            LSU_BYTE: res = {{24{t.sign_extend & b[7]}}, b};
            LSU_HALF: res = {{16{t.sign_extend & h[15]}}, h};
            default:  res = t.byte_reverse ? lsu_bswap(aligned) : aligned;
        endcase
        return res;
    endfunction

endpackage

// File: rtl/lsu_tracking_fifo.sv
// In-order tracking FIFO holding the formatting info of outstanding loads.
// Works for any DEPTH >= 2; pointers wrap explicitly at DEPTH-1.
module lsu_tracking_fifo
    import ppc_types::*;
#(
    parameter int DEPTH = 4
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         push,
    input  lsu_track_t                   push_data,
    input  logic                         pop,
    output lsu_track_t                   head,
    output logic                         full,
    output logic                         empty,
    output logic [$clog2(DEPTH+1)-1:0]   count
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = $clog2(DEPTH+1);
    localparam logic [PTR_W-1:0] LAST = PTR_W'(DEPTH - 1);

    lsu_track_t             entries_q [DEPTH];
    logic [PTR_W-1:0]       wr_ptr_q;
    logic [PTR_W-1:0]       rd_ptr_q;
    logic [CNT_W-1:0]       count_q;
    logic                   push_ok;
    logic                   pop_ok;

    assign full    = (count_q == CNT_W'(DEPTH));
    assign empty   = (count_q == '0);
    assign count   = count_q;
    assign head    = entries_q[rd_ptr_q];
    assign push_ok = push && !full;
    assign pop_ok  = pop && !empty;

    // Pointer and occupancy bookkeeping; push and pop together leave count unchanged.
    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (push_ok) begin
                wr_ptr_q <= (wr_ptr_q == LAST) ? '0 : wr_ptr_q + 1'b1;
            end
            if (pop_ok) begin
                rd_ptr_q <= (rd_ptr_q == LAST) ? '0 : rd_ptr_q + 1'b1;
            end
            case ({push_ok, pop_ok})
                2'b10:   count_q <= count_q + 1'b1;
                2'b01:   count_q <= count_q - 1'b1;
                default: count_q <= count_q;
            endcase
        end
    end

    // Entry storage needs no reset; only slots between the pointers are ever read.
    always_ff @(posedge clk) begin
        if (push_ok) begin
            entries_q[wr_ptr_q] <= push_data;
        end
    end

endmodule

// File: rtl/lsu_aligned_ppc.sv
// Two-stage load/store unit: stage 0 captures the issued op, stage 1 holds
// the effective address, lane enables and steered store data until the data
// cache accepts it. Misaligned ops are dropped with an exception pulse, and
// load responses are formatted using the in-order tracking FIFO.
module lsu_aligned_ppc
    import ppc_types::*;
#(
    parameter int RS_ID_WIDTH = 5,
    parameter int DEPTH       = 4
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   input_valid,
    output logic                   input_ready,
    input  logic [RS_ID_WIDTH-1:0] rs_id_in,
    input  logic [4:0]             result_reg_addr_in,
    input  logic [31:0]            op1,
    input  logic [31:0]            op2,
    input  logic [31:0]            source,
    input  logic                   store,
    input  lsu_control_t           control,
    output logic                   to_mem_valid,
    input  logic                   to_mem_ready,
    output logic [RS_ID_WIDTH-1:0] to_mem_rs_id,
    output logic [4:0]             to_mem_reg_addr,
    output logic [31:0]            mem_address,
    output logic [3:0]             mem_write_en,
    output logic [3:0]             mem_read_en,
    output logic [31:0]            mem_write_data,
    input  logic                   from_mem_valid,
    output logic                   from_mem_ready,
    input  logic [RS_ID_WIDTH-1:0] from_mem_rs_id,
    input  logic [4:0]             from_mem_reg_addr,
    input  logic [31:0]            mem_read_data,
    output logic                   output_valid,
    input  logic                   output_ready,
    output logic [RS_ID_WIDTH-1:0] rs_id_out,
    output logic [4:0]             result_reg_addr_out,
    output logic [31:0]            result,
    output logic                   exc_valid,
    output logic [RS_ID_WIDTH-1:0] exc_rs_id,
    output logic [31:0]            exc_address
);

    localparam int CNT_W = $clog2(DEPTH+1);

    logic                   v0_q;
    logic [RS_ID_WIDTH-1:0] rs_id0_q;
    logic [4:0]             reg0_q;
    logic [31:0]            op1_0_q;
    logic [31:0]            op2_0_q;
    logic [31:0]            src0_q;
    logic                   store0_q;
    lsu_control_t           ctrl0_q;

    logic                   v1_q;
    logic [RS_ID_WIDTH-1:0] rs_id1_q;
    logic [4:0]             reg1_q;
    logic [31:0]            ea1_q;
    logic                   store1_q;
    logic                   mis1_q;
    lsu_track_t             track1_q;
    logic [3:0]             wen1_q;
    logic [3:0]             ren1_q;
    logic [31:0]            wdata1_q;

    logic                   exc_valid_q;
    logic [RS_ID_WIDTH-1:0] exc_rs_id_q;
    logic [31:0]            exc_address_q;

    logic [31:0]            ea_d;
    logic                   mis_d;
    logic [3:0]             lanes_d;
    logic [31:0]            wdata_d;
    lsu_track_t             track_d;

    logic                   fifo_full;
    logic                   fifo_empty;
    logic [CNT_W-1:0]       fifo_count;
    lsu_track_t             fifo_head;
    logic                   accepted;
    logic                   en0;
    logic                   en1;
    logic                   push;
    logic                   pop;

    assign ea_d    = op1_0_q + op2_0_q;
    assign mis_d   = lsu_misaligned(ctrl0_q.word_size, ea_d[1:0]);
    assign lanes_d = mis_d ? 4'b0000 : lsu_lanes(ctrl0_q.word_size, ea_d[1:0]);
    assign wdata_d = (store0_q && !mis_d)
                   ? lsu_steer(src0_q, ctrl0_q.word_size, ea_d[1:0], ctrl0_q.byte_reverse)
                   : 32'h0;
    assign track_d = '{offset:       ea_d[1:0],
                       size:         ctrl0_q.word_size,
                       sign_extend:  ctrl0_q.sign_extend,
                       byte_reverse: ctrl0_q.byte_reverse};

    // A load waits while the FIFO is full, even if a response frees a slot this cycle.
    assign to_mem_valid = v1_q && !mis1_q && (store1_q || !fifo_full);
    assign accepted     = to_mem_valid && to_mem_ready;
    assign en1          = (!v1_q && v0_q) || (v1_q && (accepted || mis1_q));
    assign en0          = !v0_q || en1;
    assign input_ready  = en0;
    assign push         = accepted && !store1_q;
    assign pop          = from_mem_valid && output_ready;

    assign to_mem_rs_id    = rs_id1_q;
    assign to_mem_reg_addr = reg1_q;
    assign mem_address     = {ea1_q[31:2], 2'b00};
    assign mem_write_en    = wen1_q;
    assign mem_read_en     = ren1_q;
    assign mem_write_data  = wdata1_q;

    assign from_mem_ready      = output_ready;
    assign output_valid        = from_mem_valid;
    assign rs_id_out           = from_mem_rs_id;
    assign result_reg_addr_out = from_mem_reg_addr;
    assign result              = lsu_format(mem_read_data, fifo_head);

    assign exc_valid   = exc_valid_q;
    assign exc_rs_id   = exc_rs_id_q;
    assign exc_address = exc_address_q;

    // Stage 0: capture the issued op whenever the stage is free or moving on.
    always_ff @(posedge clk) begin
        if (rst) begin
            v0_q     <= 1'b0;
            rs_id0_q <= '0;
            reg0_q   <= '0;
            op1_0_q  <= '0;
            op2_0_q  <= '0;
            src0_q   <= '0;
            store0_q <= 1'b0;
            ctrl0_q  <= '0;
        end else if (en0) begin
            v0_q     <= input_valid;
            rs_id0_q <= rs_id_in;
            reg0_q   <= result_reg_addr_in;
            op1_0_q  <= op1;
            op2_0_q  <= op2;
            src0_q   <= source;
            store0_q <= store;
            ctrl0_q  <= control;
        end
    end

    // Stage 1: register EA, alignment verdict, lane enables and steered data.
    always_ff @(posedge clk) begin
        if (rst) begin
            v1_q     <= 1'b0;
            rs_id1_q <= '0;
            reg1_q   <= '0;
            ea1_q    <= '0;
            store1_q <= 1'b0;
            mis1_q   <= 1'b0;
            track1_q <= '0;
            wen1_q   <= '0;
            ren1_q   <= '0;
            wdata1_q <= '0;
        end else if (en1) begin
            v1_q     <= v0_q;
            rs_id1_q <= rs_id0_q;
            reg1_q   <= reg0_q;
            ea1_q    <= ea_d;
            store1_q <= store0_q;
            mis1_q   <= mis_d;
            track1_q <= track_d;
            wen1_q   <= store0_q ? lanes_d : 4'b0000;
            ren1_q   <= store0_q ? 4'b0000 : lanes_d;
            wdata1_q <= wdata_d;
        end
    end

    // One-cycle alignment exception raised as a misaligned op leaves stage 1.
    always_ff @(posedge clk) begin
        if (rst) begin
            exc_valid_q   <= 1'b0;
            exc_rs_id_q   <= '0;
            exc_address_q <= '0;
        end else begin
            exc_valid_q <= v1_q && mis1_q;
            if (v1_q && mis1_q) begin
                exc_rs_id_q   <= rs_id1_q;
                exc_address_q <= ea1_q;
            end
        end
    end

    lsu_tracking_fifo #(
        .DEPTH(DEPTH)
    ) u_fifo (
        .clk       (clk),
        .rst       (rst),
        .push      (push),
        .push_data (track1_q),
        .pop       (pop),
        .head      (fifo_head),
        .full      (fifo_full),
        .empty     (fifo_empty),
        .count     (fifo_count)
    );

    // Memory must only answer loads that are actually outstanding.
    assert property (@(posedge clk) disable iff (rst) pop |-> !fifo_empty);

    // Occupancy can never exceed the configured depth.
    assert property (@(posedge clk) disable iff (rst) fifo_count <= CNT_W'(DEPTH));

endmodule

// File: tb/tb_lsu_aligned_ppc.sv
// Directed bench for lsu_aligned_ppc: expected requests, results and
// exceptions are queued when stimulus is issued and a negedge monitor pops
// and compares whenever the DUT presents a handshake or exception pulse.
module tb_lsu_aligned_ppc;
    import ppc_types::*;

    typedef struct packed {
        logic [31:0] addr;
        logic [3:0]  wen;
        logic [3:0]  ren;
        logic [31:0] data;
        logic [4:0]  id;
        logic [4:0]  rg;
    } req_t;

    typedef struct packed {
        logic [31:0] value;
        logic [4:0]  id;
        logic [4:0]  rg;
    } res_t;

    typedef struct packed {
        logic [31:0] addr;
        logic [4:0]  id;
    } exc_t;

    logic         clk = 1'b0;
    logic         rst;
    logic         input_valid;
    logic         input_ready;
    logic [4:0]   rs_id_in;
    logic [4:0]   result_reg_addr_in;
    logic [31:0]  op1;
    logic [31:0]  op2;
    logic [31:0]  source;
    logic         store;
    lsu_control_t control;
    logic         to_mem_valid;
    logic         to_mem_ready;
    logic [4:0]   to_mem_rs_id;
    logic [4:0]   to_mem_reg_addr;
    logic [31:0]  mem_address;
    logic [3:0]   mem_write_en;
    logic [3:0]   mem_read_en;
    logic [31:0]  mem_write_data;
    logic         from_mem_valid;
    logic         from_mem_ready;
    logic [4:0]   from_mem_rs_id;
    logic [4:0]   from_mem_reg_addr;
    logic [31:0]  mem_read_data;
    logic         output_valid;
    logic         output_ready;
    logic [4:0]   rs_id_out;
    logic [4:0]   result_reg_addr_out;
    logic [31:0]  result;
    logic         exc_valid;
    logic [4:0]   exc_rs_id;
    logic [31:0]  exc_address;

    req_t expReq [$];
    res_t expRes [$];
    exc_t expExc [$];
    int   nVectors = 0;
    int   nMiscompares = 0;
    int   reqCount = 0;
    int   base;

    lsu_aligned_ppc #(
        .RS_ID_WIDTH(5),
        .DEPTH(4)
    ) dut (
        .clk                 (clk),
        .rst                 (rst),
        .input_valid         (input_valid),
        .input_ready         (input_ready),
        .rs_id_in            (rs_id_in),
        .result_reg_addr_in  (result_reg_addr_in),
        .op1                 (op1),
        .op2                 (op2),
        .source              (source),
        .store               (store),
        .control             (control),
        .to_mem_valid        (to_mem_valid),
        .to_mem_ready        (to_mem_ready),
        .to_mem_rs_id        (to_mem_rs_id),
        .to_mem_reg_addr     (to_mem_reg_addr),
        .mem_address         (mem_address),
        .mem_write_en        (mem_write_en),
        .mem_read_en         (mem_read_en),
        .mem_write_data      (mem_write_data),
        .from_mem_valid      (from_mem_valid),
        .from_mem_ready      (from_mem_ready),
        .from_mem_rs_id      (from_mem_rs_id),
        .from_mem_reg_addr   (from_mem_reg_addr),
        .mem_read_data       (mem_read_data),
        .output_valid        (output_valid),
        .output_ready        (output_ready),
        .rs_id_out           (rs_id_out),
        .result_reg_addr_out (result_reg_addr_out),
        .result              (result),
        .exc_valid           (exc_valid),
        .exc_rs_id           (exc_rs_id),
        .exc_address         (exc_address)
    );

    always #5 clk = ~clk;

    task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
        nVectors++;
        if (actual !== expected) begin
            nMiscompares++;
            $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h at %0t", name, actual, expected, $time);
        end
    endtask

    task automatic pushReq(input logic [31:0] a, input logic [3:0] w, input logic [3:0] r,
                           input logic [31:0] d, input logic [4:0] id, input logic [4:0] rg);
        expReq.push_back('{addr: a, wen: w, ren: r, data: d, id: id, rg: rg});
    endtask

    task automatic driveInput(input logic st, input logic [1:0] sz, input logic sx, input logic br,
                              input logic [31:0] a, input logic [31:0] b, input logic [31:0] s,
                              input logic [4:0] id, input logic [4:0] rg);
        input_valid        = 1'b1;
        store              = st;
        control            = {sz, sx, br};
        op1                = a;
        op2                = b;
        source             = s;
        rs_id_in           = id;
        result_reg_addr_in = rg;
    endtask

    // Called just after a rising edge; returns just after the accepting edge.
    task automatic applyStimulus(input logic st, input logic [1:0] sz, input logic sx, input logic br,
                                 input logic [31:0] a, input logic [31:0] b, input logic [31:0] s,
                                 input logic [4:0] id, input logic [4:0] rg);
        logic done;
        int   waited;
        driveInput(st, sz, sx, br, a, b, s, id, rg);
        done   = 1'b0;
        waited = 0;
        while (!done && waited < 50) begin
            @(negedge clk);
            if (input_ready) done = 1'b1;
            @(posedge clk);
            #1;
            waited++;
        end
        if (!done) checkOutput("issue_timeout", 32'd0, 32'd1);
        input_valid = 1'b0;
    endtask

    // Memory response for one outstanding load; output_ready is held high.
    task automatic respond(input logic [4:0] id, input logic [4:0] rg, input logic [31:0] word,
                           input logic [31:0] expected);
        expRes.push_back('{value: expected, id: id, rg: rg});
        from_mem_valid    = 1'b1;
        from_mem_rs_id    = id;
        from_mem_reg_addr = rg;
        mem_read_data     = word;
        @(posedge clk);
        #1;
        from_mem_valid = 1'b0;
    endtask

    // Scoreboard monitor: compares every presented handshake against the queues.
    always @(negedge clk) begin : monitor
        req_t r;
        res_t q;
        exc_t e;
        if (!rst) begin
            if (to_mem_valid && to_mem_ready) begin
                reqCount++;
                if (expReq.size() == 0) begin
                    checkOutput("unexpected_request", mem_address, 32'hFFFF_FFFF);
                end else begin
                    r = expReq.pop_front();
                    checkOutput("req_addr",  mem_address, r.addr);
                    checkOutput("req_wen",   {28'h0, mem_write_en}, {28'h0, r.wen});
                    checkOutput("req_ren",   {28'h0, mem_read_en}, {28'h0, r.ren});
                    checkOutput("req_wdata", mem_write_data, r.data);
                    checkOutput("req_tag",   {22'h0, to_mem_rs_id, to_mem_reg_addr}, {22'h0, r.id, r.rg});
                end
            end
            if (output_valid && output_ready) begin
                if (expRes.size() == 0) begin
                    checkOutput("unexpected_result", result, 32'hFFFF_FFFF);
                end else begin
                    q = expRes.pop_front();
                    checkOutput("result",     result, q.value);
                    checkOutput("result_tag", {22'h0, rs_id_out, result_reg_addr_out}, {22'h0, q.id, q.rg});
                end
            end
            if (exc_valid) begin
                if (expExc.size() == 0) begin
                    checkOutput("unexpected_exc", exc_address, 32'hFFFF_FFFF);
                end else begin
                    e = expExc.pop_front();
                    checkOutput("exc_address", exc_address, e.addr);
                    checkOutput("exc_rs_id",   {27'h0, exc_rs_id}, {27'h0, e.id});
                end
            end
        end
    end

    initial begin : watchdog
        #200000;
        $display("[TB] FAIL watchdog: simulation did not complete, %0d vectors so far", nVectors);
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        rst = 1'b1;
        input_valid = 1'b0;
        rs_id_in = '0;
        result_reg_addr_in = '0;
        op1 = '0;
        op2 = '0;
        source = '0;
        store = 1'b0;
        control = '0;
        to_mem_ready = 1'b1;
        from_mem_valid = 1'b0;
        from_mem_rs_id = '0;
        from_mem_reg_addr = '0;
        mem_read_data = '0;
        output_ready = 1'b1;
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;

        // Reset state.
        @(negedge clk);
        checkOutput("rst_input_ready",  {31'h0, input_ready}, 32'd1);
        checkOutput("rst_to_mem_valid", {31'h0, to_mem_valid}, 32'd0);
        checkOutput("rst_exc_valid",    {31'h0, exc_valid}, 32'd0);
        checkOutput("rst_mem_address",  mem_address, 32'h0);
        checkOutput("rst_enables",      {24'h0, mem_write_en, mem_read_en}, 32'h0);
        checkOutput("rst_wdata",        mem_write_data, 32'h0);
        @(posedge clk);
        #1;

        // Stores: byte, half, reversed half.
        pushReq(32'h0000_1000, 4'b0001, 4'b0000, 32'h0000_00AB, 5'd1, 5'd3);
        applyStimulus(1'b1, LSU_BYTE, 1'b0, 1'b0, 32'h1000, 32'd3, 32'h0000_00AB, 5'd1, 5'd3);
        pushReq(32'h0000_1000, 4'b0110, 4'b0000, 32'h00BE_EF00, 5'd2, 5'd4);
        applyStimulus(1'b1, LSU_HALF, 1'b0, 1'b0, 32'h1000, 32'd1, 32'hCAFE_BEEF, 5'd2, 5'd4);
        pushReq(32'h0000_1000, 4'b0011, 4'b0000, 32'h0000_3412, 5'd3, 5'd5);
        applyStimulus(1'b1, LSU_HALF, 1'b0, 1'b1, 32'h1000, 32'd2, 32'h0000_1234, 5'd3, 5'd5);

        // Reversed word store, then misaligned ops that must only raise exceptions.
        pushReq(32'h0000_3000, 4'b1111, 4'b0000, 32'h4433_2211, 5'd4, 5'd6);
        applyStimulus(1'b1, LSU_WORD, 1'b0, 1'b1, 32'h3000, 32'd0, 32'h1122_3344, 5'd4, 5'd6);
        expExc.push_back('{addr: 32'h0000_3002, id: 5'd5});
        applyStimulus(1'b0, LSU_WORD, 1'b0, 1'b0, 32'h3000, 32'd2, 32'h0, 5'd5, 5'd7);
        expExc.push_back('{addr: 32'h0000_4000, id: 5'd6});
        applyStimulus(1'b0, 2'd2, 1'b0, 1'b0, 32'h4000, 32'd0, 32'h0, 5'd6, 5'd8);
        expExc.push_back('{addr: 32'h0000_4003, id: 5'd7});
        applyStimulus(1'b1, LSU_HALF, 1'b0, 1'b0, 32'h4000, 32'd3, 32'h0000_5555, 5'd7, 5'd9);
        repeat (4) @(posedge clk);
        #1;

        // Five loads with responses withheld: four requests, fifth held.
        base = reqCount;
        pushReq(32'h0000_2000, 4'b0000, 4'b0110, 32'h0, 5'd10, 5'd11);
        applyStimulus(1'b0, LSU_HALF, 1'b1, 1'b0, 32'h2000, 32'd1, 32'h0, 5'd10, 5'd11);
        pushReq(32'h0000_2000, 4'b0000, 4'b0001, 32'h0, 5'd12, 5'd13);
        applyStimulus(1'b0, LSU_BYTE, 1'b0, 1'b0, 32'h2000, 32'd3, 32'h0, 5'd12, 5'd13);
        pushReq(32'h0000_2000, 4'b0000, 4'b0100, 32'h0, 5'd14, 5'd15);
        applyStimulus(1'b0, LSU_BYTE, 1'b1, 1'b0, 32'h2000, 32'd1, 32'h0, 5'd14, 5'd15);
        pushReq(32'h0000_2000, 4'b0000, 4'b0011, 32'h0, 5'd16, 5'd17);
        applyStimulus(1'b0, LSU_HALF, 1'b0, 1'b1, 32'h2000, 32'd2, 32'h0, 5'd16, 5'd17);
        pushReq(32'h0000_2000, 4'b0000, 4'b1111, 32'h0, 5'd18, 5'd19);
        applyStimulus(1'b0, LSU_WORD, 1'b0, 1'b1, 32'h2000, 32'd0, 32'h0, 5'd18, 5'd19);
        repeat (3) @(posedge clk);
        #1;
        @(negedge clk);
        checkOutput("full_held_valid", {31'h0, to_mem_valid}, 32'd0);
        checkOutput("full_req_count",  32'(reqCount - base), 32'd4);
        @(posedge clk);
        #1;
        expRes.push_back('{value: 32'hFFFF_F034, id: 5'd10, rg: 5'd11});
        from_mem_valid    = 1'b1;
        from_mem_rs_id    = 5'd10;
        from_mem_reg_addr = 5'd11;
        mem_read_data     = 32'h12F0_3456;
        @(negedge clk);
        checkOutput("held_during_pop", {31'h0, to_mem_valid}, 32'd0);
        @(posedge clk);
        #1;
        from_mem_valid = 1'b0;
        @(negedge clk);
        checkOutput("released_after_pop", {31'h0, to_mem_valid}, 32'd1);
        @(posedge clk);
        #1;
        respond(5'd12, 5'd13, 32'h12F0_3456, 32'h0000_0056);
        respond(5'd14, 5'd15, 32'h12F0_3456, 32'hFFFF_FFF0);
        respond(5'd16, 5'd17, 32'h12F0_3456, 32'h0000_5634);
        respond(5'd18, 5'd19, 32'h12F0_3456, 32'h5634_F012);
        checkOutput("all_req_count", 32'(reqCount - base), 32'd5);

        // Memory back-pressure for three edges under a continuous store stream.
        to_mem_ready = 1'b0;
        pushReq(32'h0000_6000, 4'b1000, 4'b0000, 32'h1100_0000, 5'd24, 5'd1);
        driveInput(1'b1, LSU_BYTE, 1'b0, 1'b0, 32'h6000, 32'd0, 32'h11, 5'd24, 5'd1);
        @(negedge clk);
        checkOutput("stall_ready_op1", {31'h0, input_ready}, 32'd1);
        @(posedge clk);
        #1;
        pushReq(32'h0000_6000, 4'b0100, 4'b0000, 32'h0022_0000, 5'd25, 5'd2);
        driveInput(1'b1, LSU_BYTE, 1'b0, 1'b0, 32'h6000, 32'd1, 32'h22, 5'd25, 5'd2);
        @(negedge clk);
        checkOutput("stall_ready_op2", {31'h0, input_ready}, 32'd1);
        @(posedge clk);
        #1;
        pushReq(32'h0000_6000, 4'b0011, 4'b0000, 32'h0000_3344, 5'd26, 5'd3);
        driveInput(1'b1, LSU_HALF, 1'b0, 1'b0, 32'h6000, 32'd2, 32'h3344, 5'd26, 5'd3);
        @(negedge clk);
        checkOutput("stall_ready_drop", {31'h0, input_ready}, 32'd0);
        @(posedge clk);
        #1;
        to_mem_ready = 1'b1;
        applyStimulus(1'b1, LSU_HALF, 1'b0, 1'b0, 32'h6000, 32'd2, 32'h3344, 5'd26, 5'd3);
        pushReq(32'h0000_6004, 4'b1111, 4'b0000, 32'hDEAD_BEEF, 5'd27, 5'd4);
        applyStimulus(1'b1, LSU_WORD, 1'b0, 1'b0, 32'h6000, 32'd4, 32'hDEAD_BEEF, 5'd27, 5'd4);
        repeat (4) @(posedge clk);
        #1;

        // Reset with two loads outstanding; stale tracking must not survive.
        pushReq(32'h0000_5000, 4'b0000, 4'b1000, 32'h0, 5'd20, 5'd1);
        applyStimulus(1'b0, LSU_BYTE, 1'b0, 1'b0, 32'h5000, 32'd0, 32'h0, 5'd20, 5'd1);
        pushReq(32'h0000_5000, 4'b0000, 4'b0011, 32'h0, 5'd21, 5'd2);
        applyStimulus(1'b0, LSU_HALF, 1'b0, 1'b0, 32'h5000, 32'd2, 32'h0, 5'd21, 5'd2);
        repeat (3) @(posedge clk);
        #1 rst = 1'b1;
        @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        checkOutput("midrst_to_mem_valid", {31'h0, to_mem_valid}, 32'd0);
        checkOutput("midrst_exc_valid",    {31'h0, exc_valid}, 32'd0);
        checkOutput("midrst_input_ready",  {31'h0, input_ready}, 32'd1);
        checkOutput("midrst_read_en",      {28'h0, mem_read_en}, 32'd0);
        @(posedge clk);
        #1;
        pushReq(32'h0000_5004, 4'b0000, 4'b1111, 32'h0, 5'd22, 5'd3);
        applyStimulus(1'b0, LSU_WORD, 1'b1, 1'b0, 32'h5000, 32'd4, 32'h0, 5'd22, 5'd3);
        pushReq(32'h0000_5004, 4'b0000, 4'b0001, 32'h0, 5'd23, 5'd4);
        applyStimulus(1'b0, LSU_BYTE, 1'b1, 1'b0, 32'h5000, 32'd7, 32'h0, 5'd23, 5'd4);
        repeat (3) @(posedge clk);
        #1;
        respond(5'd22, 5'd3, 32'h8899_AABB, 32'h8899_AABB);
        respond(5'd23, 5'd4, 32'h8899_AABB, 32'hFFFF_FFBB);

        repeat (5) @(posedge clk);
        #1;
        checkOutput("req_queue_drained", 32'(expReq.size()), 32'd0);
        checkOutput("res_queue_drained", 32'(expRes.size()), 32'd0);
        checkOutput("exc_queue_drained", 32'(expExc.size()), 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", nVectors, nMiscompares);
        $finish;
    end

endmodule

// File: doc/lsu_aligned_ppc.md
# lsu_aligned_ppc

Parametrised second-generation load/store unit between the load/store reservation station and the data cache. It computes the effective address and steers store data onto big-endian byte lanes by address offset. It supports byte-reversed accesses and flags misaligned accesses instead of issuing them. It tracks up to `DEPTH` outstanding loads so that raw memory words are returned as zero- or sign-extended, lane-extracted register results.

## Interface
- `RS_ID_WIDTH`, 5, reservation-station tag width
- `DEPTH`, 4, maximum outstanding loads (≥2)
- `clk`  in  1  clock
- `rst`  in  1  reset, synchronous, active-high
- `input_valid`/`input_ready`  in/out  1  issue handshake
- `rs_id_in`  in  RS_ID_WIDTH  tag
- `result_reg_addr_in`  in  5  destination GPR
- `op1`, `op2`  in  32  EA operands
- `source`  in  32  store data
- `store`  in  1  1 = store, 0 = load
- `control`  in  `lsu_control_t`  `{word_size[2], sign_extend, byte_reverse}`
- `to_mem_valid`/`to_mem_ready`  out/in  1  request handshake
- `to_mem_rs_id`, `to_mem_reg_addr`  out  RS_ID_WIDTH, 5  request tag
- `mem_address`  out  32  word address, bits [30:31] forced 0
- `mem_write_en`, `mem_read_en`  out  4  byte-lane enables, lane k = bits [8k:8k+7]
- `mem_write_data`  out  32  lane-steered data
- `from_mem_valid`/`from_mem_ready`  in/out  1  response handshake
- `from_mem_rs_id`, `from_mem_reg_addr`, `mem_read_data`  in  RS_ID_WIDTH, 5, 32
- `output_valid`/`output_ready`  out/in  1  result handshake
- `rs_id_out`, `result_reg_addr_out`, `result`  out  RS_ID_WIDTH, 5, 32
- `exc_valid`  out  1  alignment-exception pulse
- `exc_rs_id`, `exc_address`  out  RS_ID_WIDTH, 32  faulting tag and full EA

## Operation
- Stage 0 registers the operands and control. Stage 1 registers EA = op1+op2 (mod 2^32), offset o = EA[30:31], lane enables, and steered data.
- Sizes: `word_size` 0 = byte, 1 = half, 3 = word.
  - Legal: byte at any o; half at o ≤ 2; word at o = 0.
  - Anything else, including size 2, is misaligned.
- Store lanes: byte → lane o. Half → lanes o, o+1. Word → all lanes. `source` low-order bytes are placed MSB-first starting at lane o. `byte_reverse` swaps byte order before steering. Unused lanes are driven 0.
- Loads use the same enables on `mem_read_en`, with `mem_write_en` = 0, and push `{o, size, sign_extend, byte_reverse}` into the tracking FIFO on the `to_mem` handshake.
- Stores push nothing and produce no result.
- Response handling:
  - Pop the FIFO head on the `from_mem` handshake.
  - Extract the addressed lanes and reverse them if flagged.
  - Right-justify, then sign- or zero-extend to 32 bits.
  - Tags pass through.
- Memory returns load responses in issue order. A response arriving with the FIFO empty is a protocol violation, covered by an assertion.
- A misaligned op in stage 1 is consumed without a memory request. It raises `exc_valid` for one cycle, which cannot be back-pressured.

## Timing
- Issue to `to_mem_valid`: 2 cycles when unstalled. One op per cycle throughput.
- Stage enables:
  - en1 = (¬v1 ∧ v0) ∨ (v1 ∧ (accepted ∨ misaligned)).
  - en0 = ¬v0 ∨ en1.
  - `input_ready` = en0.
- A stage-1 load is held (`to_mem_valid` = 0) while FIFO count = `DEPTH`, even if a pop occurs that cycle. Stores are never blocked by FIFO state.
- Response path is combinational: `output_valid` = `from_mem_valid`, `from_mem_ready` = `output_ready`. Simultaneous push and pop is allowed when not full; count is unchanged.
- `exc_*` are registered from stage 1 and valid the cycle after the op leaves stage 1.
- Reset values:
  - All valids are 0 and the FIFO is empty.
  - Address, data, enables, and tags are 0.
- Reset mid-operation discards in-flight ops and FIFO entries. The memory side is reset in the same cycle.

## Structure
- `ppc_types` gains `lsu_control_t`, `lsu_track_t` and size constants `LSU_BYTE`/`LSU_HALF`/`LSU_WORD`.
- Sub-module `lsu_tracking_fifo`: parametrised `DEPTH`, pointer wrap-around, `full`/`empty`/`count`.
- Lane steering and load formatting are combinational functions in `ppc_types`.

## Test plan
- Store byte, op1=0x1000, op2=3, source=0xAB → address 0x1000, wen 0001, data 0x000000AB.
- Load half, EA 0x2001, sign_extend, memory word 0x12F0_3456 → result 0xFFFF_F034.
- Store word with byte_reverse, source 0x11223344 at 0x3000 → data 0x44332211, wen 1111. A word load at 0x3002 gives `exc_valid` with exc_address 0x3002 and no request.
- `DEPTH`=4: issue 5 loads while withholding responses → 4 requests, 5th held. The first response releases it 1 cycle later, and results come back in order with correct tags.
- Hold `to_mem_ready` low for 3 cycles with a continuous input stream → `input_ready` drops after 2 ops. No op is lost or duplicated.
- Assert `rst` with 2 loads outstanding → all valids 0 the next cycle, FIFO empty, and a new load issues normally.
